alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline: stage 1 registers the request, stage 2 computes and registers
// result, flags {N,Z,C,V} and err. A stall (result held, consumer not ready) freezes both stages.
module alu_pipe #(
  parameter int NB_OPERANDO = 8,
  parameter int NB_OPCODE   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NB_OPERANDO-1:0] dato_a,
  input  logic [NB_OPERANDO-1:0] dato_b,
  input  logic [NB_OPCODE-1:0]   opcode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB_OPERANDO-1:0] out,
  output logic [3:0]             flags,
  output logic                   err
);
  localparam int W      = NB_OPERANDO;
  localparam int STAGES = 2;
  localparam logic [W-1:0] SH_MAX = W'(W);

  localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
  localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
  localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
  localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
  localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
  localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);
  localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);
  localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
  localparam logic [NB_OPCODE-1:0] OP_SLL = NB_OPCODE'(6'b000000);

  typedef struct packed {
    logic [W-1:0]         a;
    logic [W-1:0]         b;
    logic [NB_OPCODE-1:0] op;
  } req_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         err;
  } rsp_t;

  logic [STAGES:1] vld_pipe_q;
  req_t            req_q;
  rsp_t            rsp_q, rsp_d;
  logic            stall;

  logic [W:0]   sum, shl, shr, sra;
  logic [W-1:0] diff, r;
  logic         big, c, v, e;

  assign stall     = vld_pipe_q[STAGES] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_pipe_q[STAGES];
  assign out       = rsp_q.res;
  assign flags     = rsp_q.flags;
  assign err       = rsp_q.err;

  // Shifts are done one bit wider so the last bit shifted out lands in the extra bit.
  always_comb begin
    sum  = {1'b0, req_q.a} + {1'b0, req_q.b};
    diff = req_q.a - req_q.b;
    shl  = {1'b0, req_q.a} << req_q.b;
    shr  = {req_q.a, 1'b0} >> req_q.b;
    sra  = $signed({req_q.a, 1'b0}) >>> req_q.b;
    big  = req_q.b >= SH_MAX;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    e    = 1'b0;
    case (req_q.op)
      OP_ADD: begin
        r = sum[W-1:0];
        c = sum[W];
        v = (req_q.a[W-1] == req_q.b[W-1]) && (r[W-1] != req_q.a[W-1]);
      end
      OP_SUB: begin
        r = diff;
        c = req_q.a < req_q.b;
        v = (req_q.a[W-1] != req_q.b[W-1]) && (r[W-1] != req_q.a[W-1]);
      end
      OP_AND: r = req_q.a & req_q.b;
      OP_OR:  r = req_q.a | req_q.b;
      OP_XOR: r = req_q.a ^ req_q.b;
      OP_NOR: r = ~(req_q.a | req_q.b);
      OP_SRL: if (!big) begin r = shr[W:1]; c = shr[0]; end
      OP_SRA: begin
        if (big) r = {W{req_q.a[W-1]}};
        else begin r = sra[W:1]; c = sra[0]; end
      end
      OP_SLL: if (!big) begin r = shl[W-1:0]; c = shl[W]; end
      default: e = 1'b1;
    endcase
    rsp_d.res   = r;
    rsp_d.flags = {r[W-1], r == '0, c, v};
    rsp_d.err   = e;
  end

  // Result registers only load on a real stage-1 entry so they hold while out_valid=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      req_q      <= '0;
      rsp_q      <= '0;
    end else if (!stall) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
      if (in_valid)      req_q <= '{a: dato_a, b: dato_b, op: opcode};
      if (vld_pipe_q[1]) rsp_q <= rsp_d;
    end
  end
endmodule
